// File: rtl/frame_stream_tx_if.sv
// AXI-Stream style master/slave bundle used by the frame streamer.
interface frame_stream_tx_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic [DATAWIDTH-1:0] TDATA;
  logic                 TLAST;
  logic                 TVALID;
  logic                 TREADY;

  modport master (output TDATA, output TLAST, output TVALID, input TREADY);
  modport slave  (input TDATA, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/frame_stream_tx.sv
// Frame-buffer streamer: words are written into a local RAM while idle, then
// replayed in address order on an AXI-Stream master port when START is accepted.
module frame_stream_tx #(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned MEMORYWIDTH = 8,
  parameter int unsigned ADDRWIDTH   = 12
) (
  input  logic                 CLK,
  input  logic                 ARESET,
  input  logic                 WR_EN,
  input  logic [ADDRWIDTH-1:0] WR_ADDR,
  input  logic [DATAWIDTH-1:0] WR_DATA,
  input  logic                 START,
  input  logic [ADDRWIDTH:0]   FRAME_LEN,
  frame_stream_tx_if.master    M_AXIS,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [15:0]          FRAME_CNT
);

  if (DATAWIDTH % MEMORYWIDTH != 0) begin : gen_width_check
    $error("DATAWIDTH must hold a whole number of MEMORYWIDTH pixels");
  end

  localparam logic [ADDRWIDTH:0] MaxLen  = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] AddrOne = {{ADDRWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StPrime, StStream, StFinish} state_e;

  state_e               state_q;
  logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];
  logic [ADDRWIDTH:0]   len_q;
  logic [ADDRWIDTH:0]   rd_addr_q;
  logic [DATAWIDTH-1:0] out_data_q, skid_data_q;
  logic                 out_valid_q, out_last_q;
  logic                 skid_valid_q, skid_last_q;
  logic                 busy_q, done_q, err_q;
  logic [15:0]          frame_cnt_q;

  logic [DATAWIDTH-1:0] rd_data;
  logic                 rd_last, pop, push, start_ok;

  // A read is issued only when the word is guaranteed a slot next cycle, so the
  // two-entry buffer can never overflow and no read is ever in flight unowned.
  always_comb begin
    rd_data  = mem[rd_addr_q[ADDRWIDTH-1:0]];
    rd_last  = (rd_addr_q == len_q - AddrOne);
    pop      = out_valid_q && M_AXIS.TREADY;
    push     = (state_q == StPrime) ||
               ((state_q == StStream) && (rd_addr_q != len_q) && (!skid_valid_q || pop));
    start_ok = (FRAME_LEN != '0) && (FRAME_LEN <= MaxLen);
  end

  // Buffer contents survive reset on purpose.
  always_ff @(posedge CLK) begin
    if (WR_EN && !busy_q) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      len_q        <= '0;
      rd_addr_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (WR_EN && busy_q) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (START && start_ok) begin
            len_q     <= FRAME_LEN;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StPrime;
          end else if (START) begin
            err_q <= 1'b1;
          end
        end
        StPrime, StStream: begin
          state_q <= StStream;
          if (push) begin
            rd_addr_q <= rd_addr_q + AddrOne;
          end
          if (pop && out_last_q) begin
            // The last word is always alone in the buffer when it handshakes.
            state_q     <= StFinish;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
          end else if (pop && push) begin
            if (skid_valid_q) begin
              out_data_q  <= skid_data_q;
              out_last_q  <= skid_last_q;
              skid_data_q <= rd_data;
              skid_last_q <= rd_last;
            end else begin
              out_data_q <= rd_data;
              out_last_q <= rd_last;
            end
          end else if (pop) begin
            out_valid_q  <= skid_valid_q;
            out_data_q   <= skid_data_q;
            out_last_q   <= skid_last_q;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
          end else if (push) begin
            if (out_valid_q) begin
              skid_valid_q <= 1'b1;
              skid_data_q  <= rd_data;
              skid_last_q  <= rd_last;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= rd_data;
              out_last_q  <= rd_last;
            end
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign M_AXIS.TDATA  = out_data_q;
  assign M_AXIS.TLAST  = out_last_q;
  assign M_AXIS.TVALID = out_valid_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign FRAME_CNT     = frame_cnt_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Randomised self-checking bench for frame_stream_tx against a frame-level
// model: a frame is model_mem[0..len-1] in order, TLAST on the final word.
module tb_frame_stream_tx;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   frame_len = '0;
  logic          busy, done, err;
  logic [15:0]   frame_cnt;

  frame_stream_tx_if #(.DATAWIDTH(DW)) axis ();

  frame_stream_tx #(.DATAWIDTH(DW), .MEMORYWIDTH(8), .ADDRWIDTH(AW)) dut (
    .CLK      (clk),
    .ARESET   (areset),
    .WR_EN    (wr_en),
    .WR_ADDR  (wr_addr),
    .WR_DATA  (wr_data),
    .START    (start),
    .FRAME_LEN(frame_len),
    .M_AXIS   (axis),
    .BUSY     (busy),
    .DONE     (done),
    .ERR      (err),
    .FRAME_CNT(frame_cnt)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_cnt = 0;
  logic [DW-1:0] model_mem [DEPTH];

  logic [DW-1:0] got_data[$];
  bit            got_last[$];
  int first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
  int stall_viol, zero_viol;
  bit done_busy, done_tvalid, timed_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    step();
    wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    step();
    areset = 1'b0;
    exp_cnt = 0;
  endtask

  // Starts a frame in the current cycle (cycle 0) and records every beat until
  // DONE or the cycle budget runs out. mode: 0 ready, 1 pattern 1,0,0,1, 2 random.
  task automatic collect(input int len, input int mode, input int wr_cyc, input int start_cyc);
    int            cyc = 0;
    int            k = 0;
    int            budget = len * 8 + 50;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    got_data.delete();
    got_last.delete();
    first_valid_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    stall_viol = 0; zero_viol = 0; done_busy = 1'b0; done_tvalid = 1'b0; timed_out = 1'b0;
    start = 1'b1;
    frame_len = (AW + 1)'(len);
    axis.TREADY = 1'b0;
    while (1) begin
      step();
      cyc++;
      start     = (cyc == start_cyc);
      frame_len = (cyc == start_cyc) ? '0 : (AW + 1)'(len);
      wr_en     = (cyc == wr_cyc);
      wr_addr   = AW'(2);
      wr_data   = ~model_mem[2];
      if (prev_stall && (axis.TVALID !== 1'b1 || axis.TDATA !== prev_data ||
                         axis.TLAST !== prev_last)) stall_viol++;
      if (axis.TVALID !== 1'b1 && (axis.TDATA !== '0 || axis.TLAST !== 1'b0)) zero_viol++;
      if (done === 1'b1) begin
        done_cyc = cyc; done_busy = busy; done_tvalid = axis.TVALID;
        break;
      end
      if (cyc > budget) begin
        timed_out = 1'b1;
        break;
      end
      if (axis.TVALID === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      case (mode)
        0: axis.TREADY = 1'b1;
        1: begin
          if (first_valid_cyc < 0) axis.TREADY = 1'b1;
          else begin axis.TREADY = pat[k % 4]; k++; end
        end
        default: axis.TREADY = ($urandom_range(3) != 0);
      endcase
      if (axis.TVALID === 1'b1 && axis.TREADY) begin
        got_data.push_back(axis.TDATA);
        got_last.push_back(axis.TLAST);
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        prev_stall = 1'b0;
      end else if (axis.TVALID === 1'b1) begin
        prev_stall = 1'b1; prev_data = axis.TDATA; prev_last = axis.TLAST;
      end else begin
        prev_stall = 1'b0;
      end
    end
    start = 1'b0; wr_en = 1'b0; axis.TREADY = 1'b0;
  endtask

  function automatic int bad_data(input int len);
    int b = 0;
    if (got_data.size() != len) return len + 1;
    foreach (got_data[i]) if (got_data[i] !== model_mem[i]) b++;
    return b;
  endfunction

  function automatic int bad_last(input int len);
    int b = 0;
    if (got_last.size() != len) return len + 1;
    foreach (got_last[i]) if (got_last[i] !== (i == len - 1)) b++;
    return b;
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) step();
    n_checks++;
    if ({axis.TVALID, axis.TLAST, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {axis.TVALID, axis.TLAST, busy, done, err});
    end
    n_checks++;
    if (axis.TDATA !== '0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data_cnt: got %h/%0d expected 0/0", axis.TDATA, frame_cnt);
    end
    areset = 1'b0;
    exp_cnt = 0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) write_word(i, 32'h03020100 + 32'h04040404 * i);
    collect(8, 0, -1, -1);
    exp_cnt++;
    n_checks++;
    if (bad_data(8) != 0) begin
      n_fail++; $display("FAIL basic_data: got %0d bad beats expected 0", bad_data(8));
    end
    n_checks++;
    if (bad_last(8) != 0) begin
      n_fail++; $display("FAIL basic_last: got %0d bad flags expected 0", bad_last(8));
    end
    n_checks++;
    if (first_valid_cyc != 2) begin
      n_fail++; $display("FAIL basic_tvalid_latency: got %0d expected 2", first_valid_cyc);
    end
    n_checks++;
    if (last_beat_cyc - first_beat_cyc != 7) begin
      n_fail++; $display("FAIL basic_no_bubbles: got span %0d expected 7", last_beat_cyc - first_beat_cyc);
    end
    n_checks++;
    if (done_cyc - last_beat_cyc != 1) begin
      n_fail++; $display("FAIL basic_done_delay: got %0d expected 1", done_cyc - last_beat_cyc);
    end
    n_checks++;
    if (done_busy !== 1'b0 || done_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_cycle: got busy %b tvalid %b expected 0 0", done_busy, done_tvalid);
    end
    n_checks++;
    if (frame_cnt !== 16'(exp_cnt) || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_cnt_err: got %0d/%b expected %0d/0", frame_cnt, err, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    step();
    collect(8, 1, -1, -1);
    exp_cnt++;
    n_checks++;
    if (bad_data(8) != 0 || bad_last(8) != 0) begin
      n_fail++; $display("FAIL bp_frame: got %0d/%0d bad expected 0/0", bad_data(8), bad_last(8));
    end
    n_checks++;
    if (stall_viol != 0 || zero_viol != 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d stall %0d zero violations expected 0", stall_viol, zero_viol);
    end
    n_checks++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL bp_cnt: got %0d expected %0d", frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_len1();
    step();
    collect(1, 0, -1, -1);
    exp_cnt++;
    n_checks++;
    if (bad_data(1) != 0 || bad_last(1) != 0) begin
      n_fail++; $display("FAIL len1_frame: got %0d/%0d bad expected 0/0", bad_data(1), bad_last(1));
    end
    n_checks++;
    if (first_valid_cyc != 2 || done_cyc != 3) begin
      n_fail++; $display("FAIL len1_timing: got valid %0d done %0d expected 2 3", first_valid_cyc, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    step();
    collect(2, 0, -1, -1);
    exp_cnt++;
    start = 1'b1;
    frame_len = 13'd3;
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_finish_start: got busy %b expected 0", busy);
    end
    collect(3, 0, -1, -1);
    exp_cnt++;
    n_checks++;
    if (bad_data(3) != 0 || first_valid_cyc != 2 || frame_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL b2b_frame: got bad %0d valid %0d cnt %0d expected 0 2 %0d",
               bad_data(3), first_valid_cyc, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    int len;
    for (int i = 0; i < 64; i++) write_word(i, $urandom());
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, 64);
      step();
      collect(len, 2, -1, -1);
      exp_cnt++;
      n_checks++;
      if (bad_data(len) != 0 || timed_out) begin
        n_fail++; $display("FAIL rand_data len %0d: got %0d bad timeout %b expected 0 0", len, bad_data(len), timed_out);
      end
      n_checks++;
      if (bad_last(len) != 0) begin
        n_fail++; $display("FAIL rand_last len %0d: got %0d bad expected 0", len, bad_last(len));
      end
      n_checks++;
      if (stall_viol != 0 || zero_viol != 0) begin
        n_fail++; $display("FAIL rand_stable: got %0d/%0d violations expected 0/0", stall_viol, zero_viol);
      end
      n_checks++;
      if (frame_cnt !== 16'(exp_cnt)) begin
        n_fail++; $display("FAIL rand_cnt: got %0d expected %0d", frame_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < int'(DEPTH); i++) write_word(i, $urandom());
    collect(int'(DEPTH), 2, -1, -1);
    exp_cnt++;
    n_checks++;
    if (timed_out || bad_data(int'(DEPTH)) != 0) begin
      n_fail++; $display("FAIL full_data: got %0d bad timeout %b expected 0 0", bad_data(int'(DEPTH)), timed_out);
    end
    n_checks++;
    if (bad_last(int'(DEPTH)) != 0) begin
      n_fail++; $display("FAIL full_last: got %0d bad expected 0", bad_last(int'(DEPTH)));
    end
    n_checks++;
    if (got_data.size() != int'(DEPTH) || got_data[got_data.size() - 1] !== model_mem[DEPTH - 1]) begin
      n_fail++; $display("FAIL full_last_word: got %0d beats expected %0d ending at word fff", got_data.size(), DEPTH);
    end
  endtask

  task automatic test_errors();
    bit saw = 1'b0;
    step();
    start = 1'b1;
    frame_len = '0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (axis.TVALID === 1'b1 || busy === 1'b1) saw = 1'b1;
      step();
    end
    n_checks++;
    if (saw || err !== 1'b1) begin
      n_fail++; $display("FAIL err_len0: got activity %b err %b expected 0 1", saw, err);
    end
    pulse_reset();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_reset_clear: got %b expected 0", err);
    end
    start = 1'b1;
    frame_len = 13'(DEPTH + 1);
    step();
    start = 1'b0;
    step();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL err_len_big: got err %b busy %b expected 1 0", err, busy);
    end
    pulse_reset();
    collect(8, 0, -1, 3);
    exp_cnt++;
    n_checks++;
    if (err !== 1'b0 || bad_data(8) != 0) begin
      n_fail++; $display("FAIL err_start_busy: got err %b bad %0d expected 0 0", err, bad_data(8));
    end
    step();
    collect(8, 0, 3, -1);
    exp_cnt++;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_write_busy: got %b expected 1", err);
    end
    step();
    collect(8, 2, -1, -1);
    exp_cnt++;
    n_checks++;
    if (bad_data(8) != 0) begin
      n_fail++; $display("FAIL err_write_dropped: got %0d bad expected 0", bad_data(8));
    end
  endtask

  task automatic test_midframe_reset();
    int beats = 0;
    bit hit = 1'b0;
    bit saw_done = 1'b0;
    pulse_reset();
    start = 1'b1;
    frame_len = 13'd8;
    axis.TREADY = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      start = 1'b0;
      if (axis.TVALID === 1'b1) begin
        if (beats == 3) begin
          areset = 1'b1;
          hit = 1'b1;
          break;
        end
        beats++;
      end
    end
    step();
    areset = 1'b0;
    n_checks++;
    if (!hit || axis.TVALID !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL midreset_abort: got hit %b tvalid %b busy %b cnt %0d expected 1 0 0 %0d",
               hit, axis.TVALID, busy, frame_cnt, exp_cnt);
    end
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1 || axis.TVALID === 1'b1) saw_done = 1'b1;
      step();
    end
    axis.TREADY = 1'b0;
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL midreset_quiet: got done/tvalid after reset 1 expected 0");
    end
    collect(8, 2, -1, -1);
    exp_cnt++;
    n_checks++;
    if (bad_data(8) != 0 || bad_last(8) != 0 || frame_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL midreset_replay: got bad %0d/%0d cnt %0d expected 0/0 %0d",
               bad_data(8), bad_last(8), frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_frame_count();
    int bad = 0;
    for (int f = 0; f < 300; f++) begin
      step();
      collect(1, 2, -1, -1);
      exp_cnt++;
      bad += bad_data(1) + bad_last(1) + int'(timed_out);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL count_frames: got %0d bad frames expected 0", bad);
    end
    n_checks++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL count_value: got %0d expected %0d", frame_cnt, exp_cnt);
    end
  endtask

  initial begin
    axis.TREADY = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_len1();
    test_back_to_back();
    test_random();
    test_full();
    test_errors();
    test_midframe_reset();
    test_frame_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
